gpio_run_sequencer: RTL and testbench

Control-plane front end for the RFSoC PL. It synchronises the PS GPIO control bus and deserialises the shared serial-config lines into the run-timing registers (pre-delay, cycle count, post-delay) and the channel-select register. On a PS trigger it sequences the DAC/ADC run phases. It sits between the PS GPIO block and the per-channel DAC/ADC controllers, and forwards synchronised config strobes to them.

---
 rtl/rfsoc_config_pkg.sv | 20 ++
 rtl/gpio_sync_edge.sv | 28 ++
 rtl/gpio_run_sequencer.sv | 177 +++++++++++++++++
 tb/tb_gpio_run_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfsoc_config_pkg.sv
// Shared RFSoC control-plane constants: bus widths, GPIO bit map and run FSM states.
package rfsoc_config;

    localparam int unsigned config_reg_width = 256;
    localparam int unsigned gpio_bus_width   = 16;

    // PS GPIO bit map
    localparam int unsigned sdata                = 0;
    localparam int unsigned channel_sel_clk      = 2;
    localparam int unsigned cycle_count_clk      = 3;
    localparam int unsigned pl_rst               = 5;
    localparam int unsigned trigger_line         = 6;
    localparam int unsigned pre_delay_cycle_clk  = 9;
    localparam int unsigned post_delay_cycle_clk = 10;

    localparam int unsigned run_ctr_w = config_reg_width;

    typedef enum logic [2:0] {IDLE, PRE, RUN, POST, DONE} run_state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Single-bit two-flop synchroniser with a history flop for rising-edge detection.
module gpio_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic s1_q, s2_q, s3_q;

    // Synchroniser chain plus one history stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/gpio_run_sequencer.sv
// PS GPIO front end: synchronises the bus, deserialises config registers and sequences
// the PRE/RUN/POST phases of a triggered run.
module gpio_run_sequencer
    import rfsoc_config::*;
#(
    parameter int unsigned REG_W  = config_reg_width,
    parameter int unsigned GPIO_W = gpio_bus_width
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [GPIO_W-1:0] gpio,
    output logic              cfg_sdata,
    output logic [GPIO_W-1:0] cfg_strobe,
    output logic [GPIO_W-1:0] chan_sel,
    output logic              soft_rst,
    output logic              busy,
    output logic              run_start,
    output logic              run_active,
    output logic              done,
    output logic              trig_overrun
);

    localparam logic [REG_W-1:0] CtrOne = REG_W'(1);

    logic [GPIO_W-1:0] lvl, rise;
    logic              sdata_bit, trig, unused_lvl;

    for (genvar i = 0; i < GPIO_W; i++) begin : g_sync
        gpio_sync_edge u_sync (
            .clk     (clk),
            .rstn    (rstn),
            .d_i     (gpio[i]),
            .level_o (lvl[i]),
            .rise_o  (rise[i])
        );
    end

    assign unused_lvl = ^lvl;
    assign soft_rst   = lvl[pl_rst];
    assign sdata_bit  = lvl[sdata];
    assign trig       = rise[trigger_line];

    logic [GPIO_W-1:0] strobe_q, strobe_d, chan_q, chan_d;
    logic [REG_W-1:0]  cyc_q, cyc_d, pre_q, pre_d, post_q, post_d;
    logic [REG_W-1:0]  ctr_q, ctr_d, run_len_q, run_len_d, post_len_q, post_len_d;
    logic              run_start_q, run_start_d, overrun_q, overrun_d;
    run_state_t        state_q, state_d;

    // Config shift registers and edge strobes; soft reset clears them synchronously.
    always_comb begin
        strobe_d = rise;
        chan_d   = chan_q;
        cyc_d    = cyc_q;
        pre_d    = pre_q;
        post_d   = post_q;
        if (rise[channel_sel_clk])      chan_d = {chan_q[GPIO_W-2:0], sdata_bit};
        if (rise[cycle_count_clk])      cyc_d  = {cyc_q[REG_W-2:0], sdata_bit};
        if (rise[pre_delay_cycle_clk])  pre_d  = {pre_q[REG_W-2:0], sdata_bit};
        if (rise[post_delay_cycle_clk]) post_d = {post_q[REG_W-2:0], sdata_bit};
        if (soft_rst) begin
            strobe_d = '0;
            chan_d   = '0;
            cyc_d    = '0;
            pre_d    = '0;
            post_d   = '0;
        end
    end

    // Run FSM: each phase loads len-1 and exits on zero into the next nonzero phase.
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        run_len_d   = run_len_q;
        post_len_d  = post_len_q;
        run_start_d = 1'b0;
        overrun_d   = overrun_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    run_len_d  = cyc_q;
                    post_len_d = post_q;
                    if (pre_q != '0) begin
                        state_d = PRE;
                        ctr_d   = pre_q - CtrOne;
                    end else if (cyc_q != '0) begin
                        state_d     = RUN;
                        ctr_d       = cyc_q - CtrOne;
                        run_start_d = 1'b1;
                    end else if (post_q != '0) begin
                        state_d = POST;
                        ctr_d   = post_q - CtrOne;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            PRE: begin
                if (ctr_q != '0) begin
                    ctr_d = ctr_q - CtrOne;
                end else if (run_len_q != '0) begin
                    state_d     = RUN;
                    ctr_d       = run_len_q - CtrOne;
                    run_start_d = 1'b1;
                end else if (post_len_q != '0) begin
                    state_d = POST;
                    ctr_d   = post_len_q - CtrOne;
                end else begin
                    state_d = DONE;
                end
            end
            RUN: begin
                if (ctr_q != '0) begin
                    ctr_d = ctr_q - CtrOne;
                end else if (post_len_q != '0) begin
                    state_d = POST;
                    ctr_d   = post_len_q - CtrOne;
                end else begin
                    state_d = DONE;
                end
            end
            POST: begin
                if (ctr_q != '0) ctr_d = ctr_q - CtrOne;
                else             state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (trig && (state_q != IDLE)) overrun_d = 1'b1;
        if (soft_rst) begin
            state_d     = IDLE;
            ctr_d       = '0;
            run_len_d   = '0;
            post_len_d  = '0;
            run_start_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    // State register; rstn aborts everything asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            strobe_q    <= '0;
            chan_q      <= '0;
            cyc_q       <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            state_q     <= IDLE;
            ctr_q       <= '0;
            run_len_q   <= '0;
            post_len_q  <= '0;
            run_start_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            strobe_q    <= strobe_d;
            chan_q      <= chan_d;
            cyc_q       <= cyc_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            run_len_q   <= run_len_d;
            post_len_q  <= post_len_d;
            run_start_q <= run_start_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cfg_sdata    = sdata_bit & ~soft_rst;
    assign cfg_strobe   = strobe_q;
    assign chan_sel     = chan_q;
    assign busy         = (state_q != IDLE);
    assign run_active   = (state_q == RUN);
    assign run_start    = run_start_q;
    assign done         = (state_q == DONE);
    assign trig_overrun = overrun_q;

endmodule

// File: tb/tb_gpio_run_sequencer.sv
// Bench for gpio_run_sequencer: drives the GPIO bus like the PS would and checks runs
// against phase-length arithmetic.
module tb_gpio_run_sequencer;
    import rfsoc_config::*;

    localparam int unsigned RW = 8;
    localparam int unsigned GW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic [GW-1:0] gpio;
    logic          cfg_sdata, soft_rst, busy, run_start, run_active, done, trig_overrun;
    logic [GW-1:0] cfg_strobe, chan_sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: register contents as the PS believes them to be.
    int unsigned   pre_m, cyc_m, post_m;
    logic [GW-1:0] chan_m;
    logic          overrun_m;

    gpio_run_sequencer #(.REG_W(RW), .GPIO_W(GW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .gpio         (gpio),
        .cfg_sdata    (cfg_sdata),
        .cfg_strobe   (cfg_strobe),
        .chan_sel     (chan_sel),
        .soft_rst     (soft_rst),
        .busy         (busy),
        .run_start    (run_start),
        .run_active   (run_active),
        .done         (done),
        .trig_overrun (trig_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [GW-1:0] line_mask(input int idx);
        logic [GW-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // Serial write, MSB first; data settles before each clock-line rising edge.
    task automatic shift_word(input logic [GW-1:0] mask, input logic [31:0] value,
                              input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            gpio[sdata] = value[i];
            repeat (2) @(negedge clk);
            gpio = gpio | mask;
            repeat (2) @(negedge clk);
            gpio = gpio & ~mask;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic load_timing(input int unsigned p, input int unsigned c, input int unsigned q);
        shift_word(line_mask(pre_delay_cycle_clk), p, RW);
        shift_word(line_mask(cycle_count_clk), c, RW);
        shift_word(line_mask(post_delay_cycle_clk), q, RW);
        pre_m  = p;
        cyc_m  = c;
        post_m = q;
    endtask

    task automatic trigger();
        gpio[trigger_line] = 1'b1;
        repeat (2) @(negedge clk);
        gpio[trigger_line] = 1'b0;
    endtask

    // Observes one run from first busy cycle; positions are 1-based busy cycle numbers.
    task automatic measure_run(output int b, output int r, output int s, output int spos,
                               output int d, output int dpos);
        int guard;
        b = 0; r = 0; s = 0; spos = 0; d = 0; dpos = 0; guard = 0;
        while (!busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        guard = 0;
        while (busy && guard < 3000) begin
            b++;
            if (run_active) r++;
            if (run_start) begin s++; spos = b; end
            if (done) begin d++; dpos = b; end
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic test_run_case(input string name);
        int b, r, s, spos, d, dpos, exp_b;
        trigger();
        measure_run(b, r, s, spos, d, dpos);
        exp_b = pre_m + cyc_m + post_m + 1;
        n_checks++;
        if (b !== exp_b) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d expected %0d", name, b, exp_b);
        end
        n_checks++;
        if (r !== int'(cyc_m)) begin
            n_fail++;
            $display("FAIL %s run_len: got %0d expected %0d", name, r, cyc_m);
        end
        n_checks++;
        if (s !== ((cyc_m != 0) ? 1 : 0) || (cyc_m != 0 && spos !== int'(pre_m) + 1)) begin
            n_fail++;
            $display("FAIL %s run_start: got %0d pulses at %0d expected %0d at %0d", name, s,
                     spos, (cyc_m != 0), pre_m + 1);
        end
        n_checks++;
        if (d !== 1 || dpos !== exp_b) begin
            n_fail++;
            $display("FAIL %s done: got %0d pulses at %0d expected 1 at %0d", name, d, dpos,
                     exp_b);
        end
        n_checks++;
        if (trig_overrun !== overrun_m) begin
            n_fail++;
            $display("FAIL %s overrun: got %b expected %b", name, trig_overrun, overrun_m);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, run_start, run_active, done, trig_overrun, soft_rst, cfg_sdata} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {busy, run_start, run_active, done, trig_overrun, soft_rst, cfg_sdata});
        end
        n_checks++;
        if (chan_sel !== '0 || cfg_strobe !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: chan_sel %h strobe %h expected 0", chan_sel, cfg_strobe);
        end
    endtask

    // Edge at bit sampled on edge N appears on cfg_strobe after N+2 for one cycle.
    task automatic test_strobe_latency();
        logic [GW-1:0] got [4];
        logic          sd [4];
        logic [GW-1:0] exp_s;
        exp_s = line_mask(7) | line_mask(sdata);
        gpio = gpio | exp_s;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got[i] = cfg_strobe;
            sd[i]  = cfg_sdata;
        end
        gpio = gpio & ~exp_s;
        n_checks++;
        if (got[0] !== '0 || got[1] !== '0 || got[2] !== exp_s || got[3] !== '0) begin
            n_fail++;
            $display("FAIL strobe_latency: got %h %h %h %h expected 0 0 %h 0", got[0], got[1],
                     got[2], got[3], exp_s);
        end
        n_checks++;
        if (sd[0] !== 1'b0 || sd[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sdata_sync: got %b%b expected 01", sd[0], sd[1]);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_chan_sel();
        for (int k = 0; k < 4; k++) begin
            chan_m = (k == 0) ? 16'h0004 : GW'($urandom_range(0, 65535));
            shift_word(line_mask(channel_sel_clk), 32'(chan_m), GW);
            n_checks++;
            if (chan_sel !== chan_m) begin
                n_fail++;
                $display("FAIL chan_sel[%0d]: got %h expected %h", k, chan_sel, chan_m);
            end
        end
        // Timing registers must still be zero.
        test_run_case("chan_only_zero_run");
    endtask

    task automatic test_fixed_runs();
        load_timing(3, 5, 2);  test_run_case("run_3_5_2");
        load_timing(0, 0, 0);  test_run_case("run_0_0_0");
        load_timing(0, 1, 0);  test_run_case("run_0_1_0");
        load_timing(1, 0, 1);  test_run_case("run_1_0_1");
        load_timing(0, 255, 0); test_run_case("run_max_cyc");
    endtask

    task automatic test_random_runs();
        for (int k = 0; k < 6; k++) begin
            load_timing($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
            test_run_case($sformatf("rand_run_%0d", k));
        end
    endtask

    task automatic test_simultaneous_shift();
        int unsigned v;
        v = $urandom_range(1, 9);
        shift_word(line_mask(pre_delay_cycle_clk) | line_mask(cycle_count_clk) |
                   line_mask(post_delay_cycle_clk), v, RW);
        pre_m = v; cyc_m = v; post_m = v;
        test_run_case("simultaneous_shift");
    endtask

    task automatic test_overrun();
        int b, r, s, spos, d, dpos;
        load_timing(0, 20, 0);
        trigger();
        fork
            measure_run(b, r, s, spos, d, dpos);
            begin
                repeat (8) @(negedge clk);
                trigger();
            end
        join
        overrun_m = 1'b1;
        n_checks++;
        if (r !== 20 || b !== 21) begin
            n_fail++;
            $display("FAIL overrun_run_len: got run %0d busy %0d expected 20 21", r, b);
        end
        n_checks++;
        if (trig_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_flag: got %b expected 1", trig_overrun);
        end
        repeat (3) @(negedge clk);
        test_run_case("after_overrun");
    endtask

    task automatic test_reprogram();
        int b, r, s, spos, d, dpos;
        load_timing(0, 40, 0);
        trigger();
        fork
            measure_run(b, r, s, spos, d, dpos);
            begin
                repeat (2) @(negedge clk);
                shift_word(line_mask(cycle_count_clk), 3, RW);
            end
        join
        n_checks++;
        if (r !== 40) begin
            n_fail++;
            $display("FAIL reprogram_old_len: got %0d expected 40", r);
        end
        cyc_m = 3;
        test_run_case("reprogram_new_len");
    endtask

    task automatic test_soft_reset();
        logic sr1, sr2;
        int   dones;
        chan_m = 16'h00a5;
        shift_word(line_mask(channel_sel_clk), 32'(chan_m), GW);
        load_timing(0, 20, 0);
        trigger();
        repeat (5) @(negedge clk);
        gpio[pl_rst] = 1'b1;
        dones = 0;
        @(negedge clk); sr1 = soft_rst; dones += int'(done);
        @(negedge clk); sr2 = soft_rst; dones += int'(done);
        @(negedge clk);
        n_checks++;
        if (sr1 !== 1'b0 || sr2 !== 1'b1) begin
            n_fail++;
            $display("FAIL soft_rst_sync: got %b%b expected 01", sr1, sr2);
        end
        n_checks++;
        if ({busy, run_active, run_start, trig_overrun} !== 4'b0 || chan_sel !== '0) begin
            n_fail++;
            $display("FAIL soft_rst_clear: flags %b chan %h expected 0000 0000",
                     {busy, run_active, run_start, trig_overrun}, chan_sel);
        end
        for (int i = 0; i < 4; i++) begin
            dones += int'(done);
            @(negedge clk);
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL soft_rst_no_done: got %0d done pulses expected 0", dones);
        end
        gpio[pl_rst] = 1'b0;
        repeat (4) @(negedge clk);
        pre_m = 0; cyc_m = 0; post_m = 0; overrun_m = 1'b0;
        test_run_case("after_soft_rst");
    endtask

    task automatic test_rstn();
        chan_m = 16'h5a5a;
        shift_word(line_mask(channel_sel_clk), 32'(chan_m), GW);
        load_timing(10, 2, 1);
        trigger();
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({busy, run_active, done} !== 3'b0 || chan_sel !== '0) begin
            n_fail++;
            $display("FAIL rstn_async: flags %b chan %h expected 000 0000",
                     {busy, run_active, done}, chan_sel);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        pre_m = 0; cyc_m = 0; post_m = 0;
        test_run_case("after_rstn");
    endtask

    initial begin
        rstn = 1'b0;
        gpio = '0;
        pre_m = 0; cyc_m = 0; post_m = 0; chan_m = '0; overrun_m = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        test_reset();
        test_strobe_latency();
        test_chan_sel();
        test_fixed_runs();
        test_random_runs();
        test_simultaneous_shift();
        test_overrun();
        test_reprogram();
        test_soft_reset();
        test_rstn();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
